// File: rtl/mult_seq_ctrl.sv
// Issue controller for the byte-serial multiply accumulator: takes one request,
// steps operand bytes into the two 8x8 lanes, then returns the captured result.
//
// state       | meaning
// S_IDLE      | ready for a request; acc_mode_32bit keeps its last value
// S_START     | one-cycle acc_start pulse, step counter cleared
// S_RUN       | operand byte pairs driven, one step per cycle
// S_WAIT_DONE | waiting for acc_done, bounded by TIMEOUT
// S_RESP      | response held until resp_ready
module mult_seq_ctrl #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_mode_32bit,
  input  logic [TAG_W-1:0] req_tag,
  output logic [7:0]       mul_a_1,
  output logic [7:0]       mul_b_1,
  output logic [7:0]       mul_a_2,
  output logic [7:0]       mul_b_2,
  output logic             acc_start,
  output logic             acc_mode_32bit,
  input  logic [31:0]      acc_product_1,
  input  logic [31:0]      acc_product_2,
  input  logic             acc_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t           state;
  logic [3:0]       step;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             mode_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      mul_q;

  logic [3:0] next_step;
  logic [3:0] last_step;

  assign next_step = step + 4'd1;
  assign last_step = mode_q ? 4'd15 : 4'd3;

  assign mul_a_1 = mul_q[31:24];
  assign mul_b_1 = mul_q[23:16];
  assign mul_a_2 = mul_q[15:8];
  assign mul_b_2 = mul_q[7:0];

  // Packed as {a_1, b_1, a_2, b_2}. In 16-bit mode k[1] picks the A byte and
  // k[0] the B byte of each lane's halfword; in 32-bit mode lane 2 stays idle.
  function automatic logic [31:0] sel_bytes(input logic [31:0] a, input logic [31:0] b,
                                            input logic mode, input logic [3:0] k);
    logic [31:0] r;
    logic [31:0] a_sh;
    logic [31:0] b_sh;
    r    = '0;
    a_sh = a >> {k[1:0], 3'b000};
    b_sh = b >> {k[3:2], 3'b000};
    if (mode) begin
      r[31:24] = a_sh[7:0];
      r[23:16] = b_sh[7:0];
    end else begin
      r[31:24] = k[1] ? a[15:8]  : a[7:0];
      r[23:16] = k[0] ? b[15:8]  : b[7:0];
      r[15:8]  = k[1] ? a[31:24] : a[23:16];
      r[7:0]   = k[0] ? b[31:24] : b[23:16];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      step           <= '0;
      tmo_cnt        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      mode_q         <= 1'b0;
      tag_q          <= '0;
      mul_q          <= '0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      acc_start      <= 1'b0;
      acc_mode_32bit <= 1'b0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_tag       <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_q            <= req_a;
            b_q            <= req_b;
            mode_q         <= req_mode_32bit;
            tag_q          <= req_tag;
            acc_mode_32bit <= req_mode_32bit;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            acc_start      <= 1'b1;
            state          <= S_START;
          end
        end
        S_START: begin
          acc_start <= 1'b0;
          step      <= '0;
          mul_q     <= sel_bytes(a_q, b_q, mode_q, 4'd0);
          state     <= S_RUN;
        end
        S_RUN: begin
          step <= next_step;
          if (step == last_step) begin
            mul_q   <= '0;
            tmo_cnt <= '0;
            state   <= S_WAIT_DONE;
          end else begin
            mul_q <= sel_bytes(a_q, b_q, mode_q, next_step);
          end
        end
        S_WAIT_DONE: begin
          // acc_done wins over expiry when both land in the same cycle
          if (acc_done) begin
            resp_data  <= {acc_product_2, acc_product_1};
            resp_err   <= 1'b0;
            resp_tag   <= tag_q;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_tag   <= tag_q;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: behavioural byte-serial accumulator plus a response
// scoreboard fed at request time and drained by an independent monitor.
module tb_mult_seq_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_mode_32bit;
  logic [TAG_W-1:0] req_tag;
  logic [7:0]       mul_a_1, mul_b_1, mul_a_2, mul_b_2;
  logic             acc_start;
  logic             acc_mode_32bit;
  logic [31:0]      acc_product_1;
  logic [31:0]      acc_product_2;
  logic             acc_done;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mult_seq_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode_32bit(req_mode_32bit), .req_tag(req_tag),
    .mul_a_1(mul_a_1), .mul_b_1(mul_b_1), .mul_a_2(mul_a_2), .mul_b_2(mul_b_2),
    .acc_start(acc_start), .acc_mode_32bit(acc_mode_32bit),
    .acc_product_1(acc_product_1), .acc_product_2(acc_product_2), .acc_done(acc_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural accumulator: PP cycles follow acc_start, then one DONE cycle, then acc_done.
  logic        acc_en;
  logic        inj_done;
  logic [31:0] stub_p1, stub_p2;
  int          m_cnt;
  logic        m_mode;
  logic [63:0] m_sum;
  logic [31:0] m_s1, m_s2;
  logic        m_done;
  logic [31:0] m_p1, m_p2;

  function automatic logic [63:0] pprod(input logic [7:0] x, input logic [7:0] y,
                                        input logic mode, input int k);
    logic [63:0] r;
    int sh;
    sh = mode ? 8 * ((k % 4) + (k / 4)) : 8 * ((k / 2) + (k % 2));
    r  = 64'(x);
    r  = r * 64'(y);
    return r << sh;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_p1   <= '0;
      m_p2   <= '0;
    end else begin
      m_done <= 1'b0;
      if (acc_start) begin
        m_cnt  <= 1;
        m_mode <= acc_mode_32bit;
        m_sum  <= '0;
        m_s1   <= '0;
        m_s2   <= '0;
      end else if (m_cnt >= 1 && m_cnt <= (m_mode ? 16 : 4)) begin
        m_sum <= m_sum + pprod(mul_a_1, mul_b_1, 1'b1, m_cnt - 1);
        m_s1  <= m_s1 + 32'(pprod(mul_a_1, mul_b_1, 1'b0, m_cnt - 1));
        m_s2  <= m_s2 + 32'(pprod(mul_a_2, mul_b_2, 1'b0, m_cnt - 1));
        m_cnt <= m_cnt + 1;
      end else if (m_cnt == (m_mode ? 17 : 5)) begin
        m_done <= 1'b1;
        m_p1   <= m_mode ? m_sum[31:0]  : m_s1;
        m_p2   <= m_mode ? m_sum[63:32] : m_s2;
        m_cnt  <= 0;
      end
    end
  end

  assign acc_product_1 = acc_en ? m_p1 : stub_p1;
  assign acc_product_2 = acc_en ? m_p2 : stub_p2;
  assign acc_done      = (acc_en & m_done) | inj_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];

  // Monitor: records accepts, pops an expectation on every response handshake.
  initial begin
    int   first_cyc;
    logic prev_valid;
    exp_t e;
    int   a_cyc;
    first_cyc  = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        prev_valid = 1'b0;
      end else begin
        if (req_valid && req_ready) acc_q.push_back(cyc);
        if (resp_valid && !prev_valid) first_cyc = cyc;
        prev_valid = resp_valid;
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0 || acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: actual tag %0h required none", resp_tag);
          end else begin
            e     = sb.pop_front();
            a_cyc = acc_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_tag", 64'(resp_tag), 64'(e.tag));
            chk("resp_err", 64'(resp_err), 64'(e.err));
            chk("resp_latency", 64'(first_cyc - a_cyc), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                      input logic [TAG_W-1:0] tag, input logic [63:0] ed, input logic ee,
                      input int elat, input bit push, input bit keep);
    exp_t e;
    bit   ok;
    if (push) begin
      e.data = ed; e.tag = tag; e.err = ee; e.lat = elat;
      sb.push_back(e);
    end
    req_a = a; req_b = b; req_mode_32bit = m; req_tag = tag; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_wait: actual no accept required accept for tag %0h", tag);
    end
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready && !resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: actual still busy required idle", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_acc_start"}, 64'(acc_start), 64'd0);
    chk({p, "_acc_mode"}, 64'(acc_mode_32bit), 64'd0);
    chk({p, "_mul"}, 64'({mul_a_1, mul_b_1, mul_a_2, mul_b_2}), 64'd0);
    chk({p, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({p, "_resp_data"}, resp_data, 64'd0);
    chk({p, "_resp_tag"}, 64'(resp_tag), 64'd0);
    chk({p, "_resp_err"}, 64'(resp_err), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual no finish required finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pairs16 [4];
    logic [63:0] snap_d;
    logic [TAG_W-1:0] snap_t;
    logic snap_e;
    int nz1, nz2;
    bit mode_ok, ok;

    pairs16 = '{32'h3478_0302, 32'h3456_0300, 32'h1278_0002, 32'h1256_0000};
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mode_32bit = 1'b0;
    req_tag = '0; resp_ready = 1'b1; acc_en = 1'b1; inj_done = 1'b0;
    stub_p1 = '0; stub_p2 = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 16-bit op: byte sequence and 8-cycle latency
    send(32'h0003_1234, 32'h0002_5678, 1'b0, 4'h5, 64'h00000006_06260060, 1'b0, 8, 1'b1, 1'b0);
    @(negedge clk);
    chk("start_pulse", 64'(acc_start), 64'd1);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_mul_zero", 64'({mul_a_1, mul_b_1, mul_a_2, mul_b_2}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("pair16_step%0d", k), 64'({mul_a_1, mul_b_1, mul_a_2, mul_b_2}), 64'(pairs16[k]));
    end
    @(negedge clk);
    chk("wait_mul_zero", 64'({mul_a_1, mul_b_1, mul_a_2, mul_b_2}), 64'd0);
    chk("wait_start_low", 64'(acc_start), 64'd0);
    wait_idle("idle_16");

    // 32-bit op: 16 RUN cycles, lane 2 silent, mode held
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h3, 64'hFFFFFFFE_00000001, 1'b0, 20, 1'b1, 1'b0);
    nz1 = 0; nz2 = 0; mode_ok = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (mul_a_1 != 8'd0 || mul_b_1 != 8'd0) nz1++;
      if (mul_a_2 != 8'd0 || mul_b_2 != 8'd0) nz2++;
      if (i < 19 && acc_mode_32bit !== 1'b1) mode_ok = 1'b0;
    end
    chk("run32_cycles", 64'(nz1), 64'd16);
    chk("run32_lane2", 64'(nz2), 64'd0);
    chk("mode32_held", 64'(mode_ok), 64'd1);
    wait_idle("idle_32");

    // Response backpressure
    resp_ready = 1'b0;
    send(32'h0101_00FF, 32'h0002_0003, 1'b0, 4'h9, 64'h00000202_000002FD, 1'b0, 8, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    chk("bp_resp_seen", 64'(ok), 64'd1);
    snap_d = resp_data; snap_t = resp_tag; snap_e = resp_err;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {resp_data[59:0] ^ snap_d[59:0], resp_tag ^ snap_t} | 64'({resp_err ^ snap_e, ~resp_valid}), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_after_ready", 64'(req_ready), 64'd1);
    chk("bp_after_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;

    // Timeout with a silent accumulator
    acc_en = 1'b0;
    stub_p1 = 32'hCAFE_F00D; stub_p2 = 32'h1234_5678;
    send(32'h0003_1234, 32'h0002_5678, 1'b0, 4'hA, 64'd0, 1'b1, 14, 1'b1, 1'b0);
    wait_idle("idle_tmo");

    // acc_done on the expiry cycle still counts as success
    send(32'h0003_1234, 32'h0002_5678, 1'b0, 4'hB, 64'h12345678_CAFEF00D, 1'b0, 14, 1'b1, 1'b0);
    repeat (12) begin @(posedge clk); #1; end
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    wait_idle("idle_edge");
    acc_en = 1'b1;

    // Reset in the middle of a 32-bit op at RUN step 7
    send(32'h1122_3344, 32'h5566_7788, 1'b1, 4'h7, 64'd0, 1'b0, 0, 1'b0, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("step7_bytes", 64'({mul_a_1, mul_b_1}), 64'h1177);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    send(32'h0002_0010, 32'h0003_0020, 1'b0, 4'hC, 64'h00000006_00000200, 1'b0, 8, 1'b1, 1'b0);
    wait_idle("idle_after_rst");

    // Back-to-back with req_valid held high, stray acc_done during RUN
    send(32'h0001_0001, 32'h0001_0001, 1'b0, 4'h1, 64'h00000001_00000001, 1'b0, 8, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    send(32'h00FF_00FF, 32'h00FF_00FF, 1'b0, 4'h2, 64'h0000FE01_0000FE01, 1'b0, 8, 1'b1, 1'b1);
    send(32'hFFFF_0100, 32'h0002_0100, 1'b0, 4'h3, 64'h0001FFFE_00010000, 1'b0, 8, 1'b1, 1'b1);
    req_valid = 1'b0;
    wait_idle("idle_b2b");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("accepts_drained", 64'(acc_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
